// File: rtl/serial_rx_fifo_if.sv
// serial_rx_fifo_if
//  Bundles the two handshakes around the receive FIFO:
//   - receiver side : rx_ready / rx_byte in, rxread acknowledge out
//   - CPU side      : rd_en / clr_ovr in, dout / empty / full / count /
//                     overrun out
//  Modports
//   slave  : the FIFO itself (consumes receiver bytes and CPU requests)
//   master : the environment driving it (receiver + CPU register logic)
//  Parameter AW sets the FIFO depth (2**AW); count is AW+1 bits wide.
interface serial_rx_fifo_if #(
  parameter int AW = 4
);
  logic          rx_ready;
  logic [7:0]    rx_byte;
  logic          rxread;
  logic          rd_en;
  logic [7:0]    dout;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overrun;
  logic          clr_ovr;

  modport slave (
    input  rx_ready, rx_byte, rd_en, clr_ovr,
    output rxread, dout, empty, full, count, overrun
  );

  modport master (
    output rx_ready, rx_byte, rd_en, clr_ovr,
    input  rxread, dout, empty, full, count, overrun
  );
endinterface

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo
//  Receive-side buffer sitting directly behind the UART receiver. Each
//  completed byte is taken from rx_ready/rx_byte, acknowledged with a
//  one-cycle rxread pulse and stored in a 2**AW-entry FIFO. The oldest
//  byte is presented on dout in first-word-fall-through form.
//  Ports
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   bus    : serial_rx_fifo_if.slave
//            rx_ready/rx_byte/rxread  receiver handshake
//            rd_en                    pop request (ignored when empty)
//            dout                     head byte, valid while empty=0
//            empty/full/count         registered occupancy
//            overrun                  sticky drop flag, cleared by clr_ovr
module serial_rx_fifo #(
  parameter int AW = 4
) (
  input  logic               clk,
  input  logic               reset,
  serial_rx_fifo_if.slave    bus
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            take;
  logic            rxread_q, rxread_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;
  logic            overrun_q, overrun_d;
  logic            push;
  logic            pop;
  logic            drop;
  logic [7:0]      mem [DEPTH];

  // ---------------------------------------------------------------------
  // Ingest FSM: state register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Ingest FSM: next state. WAIT holds until the receiver drops ready, so a
  // level that stays high after the acknowledge is never taken twice.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.rx_ready)  state_d = ST_WAIT;
      ST_WAIT: if (!bus.rx_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Ingest FSM: outputs. A byte is taken on the IDLE->WAIT edge; the
  // acknowledge is registered so it appears for exactly the first WAIT cycle.
  always_comb begin
    take     = (state_q == ST_IDLE) && bus.rx_ready;
    rxread_d = take;
  end

  // ---------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------
  always_comb begin
    // A pop when empty is ignored. A full FIFO can still accept a byte if
    // the head is popped on the same edge, because full implies non-empty.
    pop  = bus.rd_en && !empty_q;
    push = take && (!full_q || bus.rd_en);
    drop = take && full_q && !bus.rd_en;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));

    // A drop on the same edge as a clear wins, so no loss is ever hidden.
    overrun_d = overrun_q;
    if (drop)             overrun_d = 1'b1;
    else if (bus.clr_ovr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxread_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rxread_q  <= rxread_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: the storage array has no reset; empty qualifies dout, so stale
  // contents are never observable and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.rx_byte;
  end

  assign bus.rxread  = rxread_q;
  assign bus.dout    = mem[rd_ptr_q];
  assign bus.empty   = empty_q;
  assign bus.full    = full_q;
  assign bus.count   = count_q;
  assign bus.overrun = overrun_q;

endmodule
